// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products into an ACC_W-bit accumulator and
// hands the result downstream over a valid/ready handshake.
module product_accumulator #(
  parameter int PW      = 6,
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PW-1:0]    product,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   add_w;

  // One extra bit captures the carry out of the accumulator
  assign add_w = {1'b0, acc_q}
               + {{(ACC_W + 1 - PW){1'b0}}, product};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = add_w[ACC_W-1:0];
          cnt_d = cnt_q + 1'b1;
          if (add_w[ACC_W]) ovf_d = 1'b1;
          if (cnt_q == LAST) begin
            sum_d   = add_w[ACC_W-1:0];
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (sum_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode from state only
  assign in_ready  = (state_q == S_ACCUM);
  assign sum_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator: a true-integer model of
// each operation checked every cycle, plus literal result checks.
module tb_product_accumulator;

  localparam int PW    = 6;
  localparam int ACC_W = 8;
  localparam int NT    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PW-1:0]    product = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic             overflow;
  logic             busy;

  product_accumulator #(
    .PW(PW), .ACC_W(ACC_W), .N_TERMS(NT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .product(product), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: phase plus the exact integer total of the operation
  int m_phase = 0;
  int m_total = 0;
  int m_n     = 0;
  int m_sum   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_total = 0;
      m_n     = 0;
      m_sum   = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_total = 0;
        m_n     = 0;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_total += int'(product);
        m_n++;
        if (m_n == NT) begin
          m_sum   = m_total % 256;
          m_phase = 2;
        end
      end
    end else begin
      if (sum_ready) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
      chk("sum_valid", 32'(sum_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("sum", 32'(sum), 32'(m_sum));
      chk("overflow", 32'(overflow), 32'(m_total >= 256));
    end
  end

  int pv[NT];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit en);
    start   = en ? 1'($urandom_range(0, 1)) : 1'b0;
    product = PW'($urandom);
  endtask

  task automatic run_op(input int gap, input bit rgap,
                        input int hold, input bit nz);
    int g;
    start = 1'b1;
    sum_ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < NT; i++) begin
      g = rgap ? $urandom_range(0, gap) : (i == 0 ? 0 : gap);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        noise(nz);
        step();
      end
      in_valid = 1'b1;
      product  = PW'(pv[i]);
      start    = nz ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      in_valid = 1'b0;
      start    = 1'b0;
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = nz ? 1'($urandom_range(0, 1)) : 1'b0;
      noise(nz);
      step();
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(sum_valid), 32'd0);
    chk_en = 1'b1;

    for (int i = 0; i < NT; i++) pv[i] = i + 1;
    run_op(0, 1'b0, 0, 1'b0);
    chk("t1_sum", 32'(sum), 32'd36);
    chk("t1_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < NT; i++) pv[i] = 49;
    run_op(0, 1'b0, 0, 1'b0);
    chk("t2_sum", 32'(sum), 32'd136);
    chk("t2_ovf", 32'(overflow), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_clr", 32'(overflow), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    pv = '{5, 0, 63, 1, 1, 1, 1, 1};
    run_op(3, 1'b0, 0, 1'b0);
    chk("t3_sum", 32'(sum), 32'd73);
    chk("t3_ovf", 32'(overflow), 32'd0);

    pv = '{40, 50, 60, 10, 20, 30, 1, 2};
    run_op(1, 1'b0, 5, 1'b1);
    chk("t4_sum", 32'(sum), 32'd213);
    chk("t4_busy", 32'(busy), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    product = 6'd50;
    step();
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rsum", 32'(sum), 32'd0);
    chk("t5_rbusy", 32'(busy), 32'd0);
    for (int i = 0; i < NT; i++) pv[i] = 2;
    run_op(0, 1'b0, 0, 1'b0);
    chk("t5_sum", 32'(sum), 32'd16);

    pv = '{10, 20, 30, 40, 50, 60, 1, 2};
    run_op(2, 1'b1, 3, 1'b1);
    chk("t6_sum", 32'(sum), 32'd213);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NT; i++) pv[i] = $urandom_range(0, 63);
      run_op(2, 1'b1, $urandom_range(0, 3), 1'b1);
      for (int k = 0; k < $urandom_range(0, 2); k++) step();
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
